// File: rtl/ncl_dual_rail_sync_rx_if.sv
// ncl_dual_rail_sync_rx_if
// Bundles the NCL-facing rails and the clocked valid/ready side of the
// dual-rail receiver.
//   master : the receiver. It samples d_t/d_f/out_ready and drives comp,
//            out_data, out_valid, err and level.
//   slave  : the environment. It is the NCL pipeline plus the consumer.
// Signals:
//   d_t, d_f   [W]           true/false rails, asynchronous to clk
//   comp       1             completion back to the NCL pipeline
//   out_data   [W]           head-of-FIFO word
//   out_valid  1             FIFO non-empty
//   out_ready  1             consumer accepts the head word
//   err        1             sticky illegal-code flag
//   level      [log2(D)+1]   FIFO occupancy
interface ncl_dual_rail_sync_rx_if #(
  parameter int W     = 8,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [W-1:0]  d_t;
  logic [W-1:0]  d_f;
  logic          comp;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic          err;
  logic [LW-1:0] level;

  modport master (
    input  d_t, d_f, out_ready,
    output comp, out_data, out_valid, err, level
  );

  modport slave (
    output d_t, d_f, out_ready,
    input  comp, out_data, out_valid, err, level
  );
endinterface

// File: rtl/ncl_dual_rail_sync_rx.sv
// ncl_dual_rail_sync_rx
// Terminates an NCL dual-rail pipeline into the clk domain. The rails pass
// through 2-flop synchronizers plus a third stage used for a stability
// compare. A complete, stable DATA wavefront is pushed into a FWFT FIFO and
// acknowledged through comp. A complete, stable NULL wavefront clears comp.
// When the FIFO is full, completion is withheld, which stalls the NCL side.
// Ports:
//   clk     receiver clock
//   init_n  asynchronous active-low reset. Its release is synchronized
//           internally.
//   bus     ncl_dual_rail_sync_rx_if.master: rails in, comp, FIFO
//           valid/ready side, err and level
module ncl_dual_rail_sync_rx #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    init_n,
  ncl_dual_rail_sync_rx_if.master bus
);
  localparam int        AW     = $clog2(DEPTH);
  localparam logic [AW:0] FULL_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_L  = (AW+1)'(1);

  typedef enum logic {WAIT_DATA = 1'b0, WAIT_NULL = 1'b1} state_e;

  // Reset is asserted asynchronously and released through two flops, so
  // every state flop leaves reset on the same clk edge.
  logic rst_s1_q;
  logic rst_n_q;

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      rst_s1_q <= 1'b0;
      rst_n_q  <= 1'b0;
    end else begin
      rst_s1_q <= 1'b1;
      rst_n_q  <= rst_s1_q;
    end
  end

  // Rail synchronizers: s1/s2 resolve metastability, s3 is a one-sample
  // history of s2 used for the stability check.
  logic [W-1:0] t_s1_q, t_s2_q, t_s3_q;
  logic [W-1:0] f_s1_q, f_s2_q, f_s3_q;

  always_ff @(posedge clk or negedge rst_n_q) begin
    if (!rst_n_q) begin
      t_s1_q <= '0;
      t_s2_q <= '0;
      t_s3_q <= '0;
      f_s1_q <= '0;
      f_s2_q <= '0;
      f_s3_q <= '0;
    end else begin
      t_s1_q <= bus.d_t;
      t_s2_q <= t_s1_q;
      t_s3_q <= t_s2_q;
      f_s1_q <= bus.d_f;
      f_s2_q <= f_s1_q;
      f_s3_q <= f_s2_q;
    end
  end

  // Wavefront decode on s2. An illegal bit is not one-hot, so it can never
  // satisfy the all-DATA test. This means it blocks the push with no extra
  // gating.
  logic [W-1:0] bit_data;
  logic [W-1:0] bit_ill;
  logic         stable;
  logic         cdata;
  logic         cnull;
  logic         illegal;

  always_comb begin
    bit_data = t_s2_q ^ f_s2_q;
    bit_ill  = t_s2_q & f_s2_q;
    stable   = (t_s2_q == t_s3_q) && (f_s2_q == f_s3_q);
    cdata    = (&bit_data) && stable;
    cnull    = ~|(t_s2_q | f_s2_q) && stable;
    illegal  = |bit_ill;
  end

  // FIFO bookkeeping
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   level_q, level_d;
  state_e        state_q;
  logic          comp_q;
  logic          err_q;
  logic          valid;
  logic          pop;
  logic          space;
  logic          push;

  always_comb begin
    valid = (level_q != '0);
    pop   = valid && bus.out_ready;
    // A full FIFO still accepts a push on the edge where it also pops.
    space = (level_q != FULL_L) || pop;
    push  = (state_q == WAIT_DATA) && cdata && space;
    wr_d  = wr_q + AW'(push);
    rd_d  = rd_q + AW'(pop);
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + ONE_L;
      2'b01:   level_d = level_q - ONE_L;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n_q) begin
    if (!rst_n_q) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end

  // Storage holds data only. It needs no reset because out_data is masked
  // while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= t_s2_q;
    end
  end

  // Completion FSM. comp is registered so the NCL side never sees a glitch.
  always_ff @(posedge clk or negedge rst_n_q) begin
    if (!rst_n_q) begin
      state_q <= WAIT_DATA;
      comp_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= err_q | illegal;
      case (state_q)
        WAIT_DATA: begin
          if (push) begin
            state_q <= WAIT_NULL;
            comp_q  <= 1'b1;
          end
        end
        WAIT_NULL: begin
          if (cnull) begin
            state_q <= WAIT_DATA;
            comp_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= WAIT_DATA;
          comp_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.comp      = comp_q;
  assign bus.err       = err_q;
  assign bus.level     = level_q;
  assign bus.out_valid = valid;
  assign bus.out_data  = valid ? mem_q[rd_q] : '0;
endmodule

// File: tb/tb_ncl_dual_rail_sync_rx.sv
module tb_ncl_dual_rail_sync_rx;
  localparam int W     = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic init_n;
  always #5 clk = ~clk;

  ncl_dual_rail_sync_rx_if #(.W(W), .DEPTH(DEPTH)) dif();

  ncl_dual_rail_sync_rx #(.W(W), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .init_n (init_n),
    .bus    (dif)
  );

  int vectors     = 0;
  int miscompares = 0;
  logic [W-1:0] sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drive_data(input logic [W-1:0] w);
    dif.d_t = w;
    dif.d_f = ~w;
  endtask

  task automatic drive_null();
    dif.d_t = '0;
    dif.d_f = '0;
  endtask

  // Counts clk edges until comp reaches v. The count starts at the drive point.
  task automatic wait_comp(input logic v, input int lo, input int hi, input string tag);
    int n = 0;
    while (dif.comp !== v && n < hi + 2) begin
      @(posedge clk);
      #2;
      n++;
    end
    check({tag, "_comp"}, 32'(dif.comp), 32'(v));
    vectors++;
    assert ((n >= lo) && (n <= hi)) else begin
      miscompares++;
      $error("FAIL %s_latency: observed %0d edges expected %0d..%0d", tag, n, lo, hi);
    end
  endtask

  task automatic token(input logic [W-1:0] w, input string tag);
    sb.push_back(w);
    drive_data(w);
    wait_comp(1'b1, 4, 5, tag);
    drive_null();
    wait_comp(1'b0, 4, 5, {tag, "_null"});
  endtask

  task automatic drain(input string tag);
    int n = 0;
    dif.out_ready = 1'b1;
    while (dif.level !== '0 && n < 40) begin
      tick(1);
      n++;
    end
    check({tag, "_drained"}, 32'(dif.level), 32'd0);
    dif.out_ready = 1'b0;
  endtask

  // Scoreboard: each accepted word must be the next expected word.
  always @(negedge clk) begin
    if (init_n === 1'b1 && dif.out_valid === 1'b1 && dif.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("pop_unexpected", 32'(sb.size()), 32'd1);
      end else begin
        logic [W-1:0] e;
        e = sb.pop_front();
        check("pop_data", 32'(dif.out_data), 32'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    init_n        = 1'b0;
    dif.out_ready = 1'b0;
    drive_null();
    tick(3);
    check("rst_comp",  32'(dif.comp),      32'd0);
    check("rst_valid", 32'(dif.out_valid), 32'd0);
    check("rst_level", 32'(dif.level),     32'd0);
    check("rst_err",   32'(dif.err),       32'd0);
    check("rst_data",  32'(dif.out_data),  32'd0);
    init_n = 1'b1;
    tick(4);
    check("post_rst_comp", 32'(dif.comp), 32'd0);

    // Single token
    sb.push_back(8'hA5);
    dif.d_t = 8'hA5;
    dif.d_f = 8'h5A;
    wait_comp(1'b1, 4, 5, "single");
    check("single_valid", 32'(dif.out_valid), 32'd1);
    check("single_data",  32'(dif.out_data),  32'hA5);
    check("single_level", 32'(dif.level),     32'd1);
    drive_null();
    wait_comp(1'b0, 4, 5, "single_null");
    drain("single");

    // Stream with stalls
    for (int i = 1; i <= 4; i++) token(8'(i), "stream");
    check("stream_full", 32'(dif.level), 32'd4);
    sb.push_back(8'h05);
    drive_data(8'h05);
    tick(10);
    check("stream_stall_comp",  32'(dif.comp),  32'd0);
    check("stream_stall_level", 32'(dif.level), 32'd4);
    dif.out_ready = 1'b1;
    wait_comp(1'b1, 1, 2, "stream_5th");
    drive_null();
    wait_comp(1'b0, 4, 5, "stream_5th_null");
    token(8'h06, "stream_6th");
    drain("stream");

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 4; i++) token(8'(8'h11 + i), "full");
    check("full_level", 32'(dif.level), 32'd4);
    sb.push_back(8'h77);
    drive_data(8'h77);
    tick(8);
    check("full_pending_comp", 32'(dif.comp), 32'd0);
    dif.out_ready = 1'b1;
    tick(1);
    dif.out_ready = 1'b0;
    check("full_pushpop_level", 32'(dif.level), 32'd4);
    check("full_pushpop_comp",  32'(dif.comp),  32'd1);
    drive_null();
    wait_comp(1'b0, 4, 5, "full_null");
    drain("full");

    // Skewed arrival, one bit per cycle
    drive_null();
    for (int i = 0; i < W; i++) begin
      if (i == W - 1) begin
        tick(2);
        check("skew_gap_level", 32'(dif.level), 32'd0);
      end
      if (8'hC3 & (8'd1 << i)) dif.d_t[i] = 1'b1;
      else                     dif.d_f[i] = 1'b1;
      if (i < W - 1) begin
        tick(1);
        check("skew_partial_comp",  32'(dif.comp),  32'd0);
        check("skew_partial_level", 32'(dif.level), 32'd0);
      end
    end
    sb.push_back(8'hC3);
    wait_comp(1'b1, 4, 5, "skew");
    tick(6);
    check("skew_once_level", 32'(dif.level), 32'd1);
    drive_null();
    wait_comp(1'b0, 4, 5, "skew_null");
    drain("skew");

    // Illegal code on bit 3
    check("pre_ill_err", 32'(dif.err), 32'd0);
    dif.d_t = 8'h5C;
    dif.d_f = 8'hAB;
    tick(8);
    check("ill_err",   32'(dif.err),   32'd1);
    check("ill_comp",  32'(dif.comp),  32'd0);
    check("ill_level", 32'(dif.level), 32'd0);
    sb.push_back(8'h5C);
    dif.d_f = 8'hA3;
    wait_comp(1'b1, 4, 5, "ill_fix");
    check("ill_fix_level", 32'(dif.level), 32'd1);
    drive_null();
    wait_comp(1'b0, 4, 5, "ill_fix_null");
    drain("ill");
    check("ill_err_sticky", 32'(dif.err), 32'd1);

    // Reset in mid-operation
    token(8'h21, "mid");
    token(8'h22, "mid");
    sb.push_back(8'h23);
    drive_data(8'h23);
    wait_comp(1'b1, 4, 5, "mid3");
    check("mid_level3", 32'(dif.level), 32'd3);
    init_n = 1'b0;
    #1;
    check("arst_comp",  32'(dif.comp),      32'd0);
    check("arst_valid", 32'(dif.out_valid), 32'd0);
    check("arst_level", 32'(dif.level),     32'd0);
    check("arst_err",   32'(dif.err),       32'd0);
    check("arst_data",  32'(dif.out_data),  32'd0);
    sb.delete();
    drive_data(8'h3C);
    tick(3);
    init_n = 1'b1;
    sb.push_back(8'h3C);
    wait_comp(1'b1, 6, 7, "recap");
    tick(6);
    check("recap_once_level", 32'(dif.level),    32'd1);
    check("recap_data",       32'(dif.out_data), 32'h3C);
    drive_null();
    wait_comp(1'b0, 4, 5, "recap_null");
    drain("recap");
    check("sb_leftover", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
